piso_serializer: RTL

Parallel-in/serial-out shifter that accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on a serial line with frame and last-bit strobes. It is the transmit end of the team's serial bit-pipeline: its serial output feeds a shift-register receiver/deserializer chain clocked by the same clock. It supports back-to-back words with no idle gap.

---
 rtl/piso_serializer.sv | 92 +++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: loads a WIDTH-bit word on a valid/ready
// handshake and streams it out one bit per clock with frame and last strobes.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             ser_o,
  output logic             frame_o,
  output logic             last_o
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             last_q, last_d;
  logic             accept;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
    end
  end

  // The shift register is cleared on the way back to IDLE so the serial
  // line reads 0 whenever no frame is in progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = data_i;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          if (accept) begin
            cnt_d   = '0;
            shreg_d = data_i;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase
    last_d = (state_d == SHIFT) && (cnt_d == CNT_LAST);
  end

  always_comb begin
    ready_o = (state_q == IDLE) || (cnt_q == CNT_LAST);
    accept  = valid_i && ready_o;
    frame_o = (state_q == SHIFT);
    ser_o   = frame_o && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    last_o  = last_q;
  end

endmodule
